// File: rtl/alu.sv
// Registered ALU: add, subtract, AND, OR with carry/zero/negative/overflow.
// One operation per cycle, result visible one rising edge after issue.
module alu #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       alu_op,
    output logic [WIDTH-1:0] alu_out,
    output logic             carry,
    output logic             zero,
    output logic             negative,
    output logic             overflow
);

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_OR  = 2'b11
    } op_e;

    localparam int MSB = WIDTH - 1;

    op_e              op;
    logic             is_sub;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             arith_ovf;

    logic [WIDTH-1:0] res_d;
    logic             carry_d;
    logic             ovf_d;
    logic             zero_d;
    logic             neg_d;

    assign op     = op_e'(alu_op);
    assign is_sub = (op == OP_SUB);

    // Shared adder: subtraction is a + ~b + 1.
    always_comb begin
        b_eff   = is_sub ? ~b : b;
        sum_ext = {1'b0, a}
                + {1'b0, b_eff}
                + {{WIDTH{1'b0}}, is_sub};
        sum     = sum_ext[MSB:0];
        cout    = sum_ext[WIDTH];
        // Same-sign operands into the adder yielding opposite-sign sum.
        arith_ovf = (a[MSB] == b_eff[MSB])
                 && (sum[MSB] != a[MSB]);
    end

    // Result and flag selection for the next register load.
    always_comb begin
        res_d   = '0;
        carry_d = 1'b0;
        ovf_d   = 1'b0;
        unique case (op)
            OP_ADD: begin
                res_d   = sum;
                carry_d = cout;
                ovf_d   = arith_ovf;
            end
            OP_SUB: begin
                res_d   = sum;
                // No carry-out of a + ~b + 1 means a < b: a borrow.
                carry_d = ~cout;
                ovf_d   = arith_ovf;
            end
            OP_AND: res_d = a & b;
            OP_OR:  res_d = a | b;
        endcase
        zero_d = (res_d == '0);
        neg_d  = res_d[MSB];
    end

    // Output register with synchronous reset taking priority.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_out  <= '0;
            carry    <= 1'b0;
            zero     <= 1'b0;
            negative <= 1'b0;
            overflow <= 1'b0;
        end else begin
            alu_out  <= res_d;
            carry    <= carry_d;
            zero     <= zero_d;
            negative <= neg_d;
            overflow <= ovf_d;
        end
    end

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: driver queues expected results,
// monitor compares after each edge and again just before the next.
module tb_alu;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   alu_op;
    logic [W-1:0] alu_out;
    logic         carry;
    logic         zero;
    logic         negative;
    logic         overflow;

    typedef struct {
        string        name;
        logic [W-1:0] res;
        logic         c;
        logic         z;
        logic         n;
        logic         v;
    } exp_t;

    exp_t q[$];
    int   n_tests;
    int   n_fail;
    bit   done;

    localparam logic [1:0] ADD = 2'b00;
    localparam logic [1:0] SUB = 2'b01;
    localparam logic [1:0] AND = 2'b10;
    localparam logic [1:0] OR  = 2'b11;

    alu #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .a        (a),
        .b        (b),
        .alu_op   (alu_op),
        .alu_out  (alu_out),
        .carry    (carry),
        .zero     (zero),
        .negative (negative),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input exp_t e, input string tag);
        logic [W+3:0] got;
        logic [W+3:0] want;
        got  = {alu_out, carry, zero, negative, overflow};
        want = {e.res, e.c, e.z, e.n, e.v};
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s/%s: got out=%b c%b z%b n%b v%b, want out=%b c%b z%b n%b v%b",
                     e.name, tag, alu_out, carry, zero, negative, overflow,
                     e.res, e.c, e.z, e.n, e.v);
        end
    endtask

    // Monitor: compare right after the edge, then re-check hold late in cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check(e, "edge");
                #7;
                check(e, "hold");
            end
        end
    end

    task automatic step(input string name, input logic rst,
                        input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic [1:0] op, input logic [W-1:0] res,
                        input logic c, input logic z,
                        input logic n, input logic v);
        exp_t e;
        rst_n  = rst;
        a      = ta;
        b      = tb;
        alu_op = op;
        e.name = name;
        e.res  = res;
        e.c    = c;
        e.z    = z;
        e.n    = n;
        e.v    = v;
        q.push_back(e);
        @(negedge clk);
    endtask

    // Drive a different operation first, then settle on the real one.
    task automatic glitch_step(input string name,
                               input logic [W-1:0] ta, input logic [W-1:0] tb,
                               input logic [1:0] op, input logic [W-1:0] res,
                               input logic c, input logic z,
                               input logic n, input logic v);
        rst_n  = 1'b1;
        a      = 4'd15;
        b      = 4'd15;
        alu_op = ADD;
        #2;
        step(name, 1'b1, ta, tb, op, res, c, z, n, v);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        done    = 1'b0;
        step("reset",     1'b0, 4'd9,  4'd3, ADD, 4'b0000, 0, 0, 0, 0);
        step("release",   1'b1, 4'd9,  4'd3, ADD, 4'b1100, 0, 0, 1, 0);
        step("add_4_6",   1'b1, 4'd4,  4'd6, ADD, 4'b1010, 0, 0, 1, 1);
        step("sub_4_6",   1'b1, 4'd4,  4'd6, SUB, 4'b1110, 1, 0, 1, 0);
        step("and_4_6",   1'b1, 4'd4,  4'd6, AND, 4'b0100, 0, 0, 0, 0);
        step("or_4_6",    1'b1, 4'd4,  4'd6, OR,  4'b0110, 0, 0, 0, 0);
        step("add_wrap",  1'b1, 4'd15, 4'd1, ADD, 4'b0000, 1, 1, 0, 0);
        step("sub_wrap",  1'b1, 4'd0,  4'd1, SUB, 4'b1111, 1, 0, 1, 0);
        step("add_ovf",   1'b1, 4'd7,  4'd1, ADD, 4'b1000, 0, 0, 1, 1);
        step("sub_ovf",   1'b1, 4'd8,  4'd1, SUB, 4'b0111, 0, 0, 0, 1);
        step("sub_equal", 1'b1, 4'd5,  4'd5, SUB, 4'b0000, 0, 1, 0, 0);
        glitch_step("late_and", 4'd12, 4'd10, AND, 4'b1000, 0, 0, 1, 0);
        glitch_step("late_or",  4'd3,  4'd4,  OR,  4'b0111, 0, 0, 0, 0);
        step("mid_reset", 1'b0, 4'd15, 4'd1, ADD, 4'b0000, 0, 0, 0, 0);
        step("post_sub",  1'b1, 4'd3,  4'd5, SUB, 4'b1110, 1, 0, 1, 0);
        step("and_zero",  1'b1, 4'd0,  4'd15, AND, 4'b0000, 0, 1, 0, 0);
        step("or_ones",   1'b1, 4'd9,  4'd6, OR,  4'b1111, 0, 0, 1, 0);
        repeat (3) @(negedge clk);
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d results left, want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5000;
        $display("FAIL timeout: bench did not finish, want finish by 5000");
        $fatal(1);
    end

endmodule
